// File: rtl/vlsu_mem_fence_pkg.sv
// Shared AXI channel types for the vector load/store fence.
// Holds the default request/response bundle types and their field widths.
// The fence itself only adds module-local types on top of these.
package vlsu_mem_fence_pkg;

  localparam int unsigned DefAddrWidth = 64;
  localparam int unsigned DefDataWidth = 128;
  localparam int unsigned DefIdWidth   = 4;
  localparam int unsigned DefStrbWidth = DefDataWidth / 8;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } axi_ax_t;

  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [DefStrbWidth-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [1:0]            resp;
  } axi_b_t;

  typedef struct packed {
    logic [DefIdWidth-1:0]   id;
    logic [DefDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_resp_t;

endpackage

// File: rtl/vlsu_mem_fence.sv
// Read-after-write fence for the vector load/store unit AXI master port.
// Tracks in-flight store bursts (AW handshake to B response) in a small
// circular table and holds back any load AR whose byte range overlaps one.
//
// Ports:
//   clk_i            clock
//   rst_ni           asynchronous active-low reset
//   slv_req_i        requests from the vector load/store unit
//   slv_resp_o       responses to the vector load/store unit
//   mst_req_o        requests towards memory
//   mst_resp_i       responses from memory
//   wr_outstanding_o number of tracked store bursts (registered count)
//   ar_stall_o       high while a presented AR is held back by an overlap
module vlsu_mem_fence
  import vlsu_mem_fence_pkg::*;
#(
  parameter int unsigned NrOutstanding = 4,
  parameter int unsigned AxiAddrWidth  = DefAddrWidth,
  parameter int unsigned AxiDataWidth  = DefDataWidth,
  parameter type axi_req_t  = vlsu_mem_fence_pkg::axi_req_t,
  parameter type axi_resp_t = vlsu_mem_fence_pkg::axi_resp_t
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  axi_req_t                           slv_req_i,
  output axi_resp_t                          slv_resp_o,
  output axi_req_t                           mst_req_o,
  input  axi_resp_t                          mst_resp_i,
  output logic [$clog2(NrOutstanding+1)-1:0] wr_outstanding_o,
  output logic                               ar_stall_o
);

  localparam int unsigned CntWidth = $clog2(NrOutstanding + 1);
  localparam int unsigned PtrWidth = $clog2(NrOutstanding);
  localparam int unsigned MaxSize  = $clog2(AxiDataWidth / 8);

  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef logic [PtrWidth-1:0]     ptr_t;
  typedef logic [CntWidth-1:0]     cnt_t;

  typedef struct packed {
    addr_t start;
    addr_t last;
  } entry_t;

  if ((NrOutstanding < 2) || ((NrOutstanding & (NrOutstanding - 1)) != 0)) begin : g_bad_depth
    $error("NrOutstanding must be a power of two and at least 2");
  end
  if (AxiDataWidth < 8) begin : g_bad_data
    $error("AxiDataWidth must be at least one byte");
  end

  // Inclusive byte range of an INCR burst. The end is formed one bit wider
  // than the address so a burst running off the top of the address space
  // clamps to all-ones instead of wrapping to a low address.
  function automatic entry_t make_range(addr_t start, logic [7:0] len, logic [2:0] size);
    logic [AxiAddrWidth:0] bytes;
    logic [AxiAddrWidth:0] sum;
    entry_t                rng;
    bytes     = ((AxiAddrWidth+1)'(len) + (AxiAddrWidth+1)'(1)) << size;
    sum       = {1'b0, start} + bytes - (AxiAddrWidth+1)'(1);
    rng.start = start;
    rng.last  = sum[AxiAddrWidth] ? '1 : sum[AxiAddrWidth-1:0];
    return rng;
  endfunction

  function automatic logic ranges_overlap(entry_t a, entry_t b);
    return (a.start <= b.last) && (b.start <= a.last);
  endfunction

  entry_t                   tbl_q [NrOutstanding];
  logic [NrOutstanding-1:0] vld_q, vld_nxt;
  ptr_t                     rd_ptr_q, wr_ptr_q;
  cnt_t                     cnt_q;

  entry_t aw_rng, ar_rng;
  logic   full, push, pop, ar_overlap;

  assign aw_rng = make_range(AxiAddrWidth'(slv_req_i.aw.addr), slv_req_i.aw.len, slv_req_i.aw.size);
  assign ar_rng = make_range(AxiAddrWidth'(slv_req_i.ar.addr), slv_req_i.ar.len, slv_req_i.ar.size);

  // No bypass: a B popping in the same cycle does not free a slot for AW.
  assign full = (cnt_q == CntWidth'(NrOutstanding));
  assign push = slv_req_i.aw_valid && !full && mst_resp_i.aw_ready;
  assign pop  = mst_resp_i.b_valid && slv_req_i.b_ready && (cnt_q != '0);

  // An AW presented alongside the AR is treated as the older access.
  // The table is checked before this cycle's pop, so release lags a B by one.
  always_comb begin
    ar_overlap = 1'b0;
    for (int i = 0; i < NrOutstanding; i++) begin
      if (vld_q[i] && ranges_overlap(tbl_q[i], ar_rng)) begin
        ar_overlap = 1'b1;
      end
    end
    if (slv_req_i.aw_valid && ranges_overlap(aw_rng, ar_rng)) begin
      ar_overlap = 1'b1;
    end
  end

  always_comb begin
    mst_req_o           = slv_req_i;
    slv_resp_o          = mst_resp_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid && !full;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && !full;
    mst_req_o.ar_valid  = slv_req_i.ar_valid && !ar_overlap;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && !ar_overlap;
  end

  assign ar_stall_o       = slv_req_i.ar_valid && ar_overlap;
  assign wr_outstanding_o = cnt_q;

  always_comb begin
    vld_nxt = vld_q;
    if (pop) begin
      vld_nxt[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      vld_nxt[wr_ptr_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      vld_q <= vld_nxt;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + cnt_t'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - cnt_t'(1);
      end
    end
  end

  // Entry payload needs no reset: it is only observed through vld_q.
  always_ff @(posedge clk_i) begin
    if (push) begin
      tbl_q[wr_ptr_q] <= aw_rng;
    end
  end

  a_b_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mst_resp_i.b_valid && slv_req_i.b_ready) |-> (cnt_q != '0))
    else $error("B response with no outstanding store burst");

  a_aw_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.aw_valid |-> (32'(slv_req_i.aw.size) <= MaxSize))
    else $error("AW size exceeds data bus width");

endmodule
